// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: the mult/div sequencer
// state encoding, the register-specifier width and the hardwired zero register.
package mips_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam int MD_LATENCY_DEFAULT = 32;

endpackage

// File: rtl/md_busy_counter.sv
// Countdown for the multi-cycle mult/div unit: loads on issue, decrements while
// busy, and flags the final busy cycle.
module md_busy_counter #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic busy,
    output logic cnt_zero,
    output logic md_done
);

    localparam int CNT_W = $clog2(MD_LATENCY);

    logic [CNT_W-1:0] md_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= CNT_W'(MD_LATENCY - 1);
        end else if (busy && (md_cnt != '0)) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign cnt_zero = (md_cnt == '0);
    assign md_done  = busy & cnt_zero & ~reset;

endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer beside the ID-stage forwarding unit: load-use bubbles,
// taken-branch flushes, mult/div dependency stalls and a stall-cycle counter.
module hazard_stall_controller
    import mips_pkg::*;
#(
    parameter int MD_LATENCY  = MD_LATENCY_DEFAULT,
    parameter int REG_ADDR_W  = mips_pkg::REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  IF_ID_RS,
    input  logic [REG_ADDR_W-1:0]  IF_ID_RT,
    input  logic                   ID_uses_RT,
    input  logic [REG_ADDR_W-1:0]  ID_EX_RT,
    input  logic                   ID_EX_Mem_Read,
    input  logic                   EX_branch_taken,
    input  logic                   ID_md_start,
    input  logic                   ID_md_read,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   ID_EX_Bubble,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    md_state_t state, state_nxt;
    logic      cnt_zero;
    logic      load_use;
    logic      md_conf;
    logic      stall;
    logic      flush;
    logic      md_accept;

    assign load_use = ID_EX_Mem_Read
                    & (ID_EX_RT != REG_ADDR_W'(ZERO_REG))
                    & ((ID_EX_RT == IF_ID_RS) | (ID_uses_RT & (ID_EX_RT == IF_ID_RT)));

    assign md_conf   = (state == MD_BUSY) & ~cnt_zero & (ID_md_start | ID_md_read);
    assign flush     = ~reset & EX_branch_taken;
    assign stall     = ~reset & ~EX_branch_taken & (load_use | md_conf);
    assign md_accept = ~reset & ID_md_start & ~EX_branch_taken & ~load_use & ~md_conf;

    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (md_accept),
        .busy     (state == MD_BUSY),
        .cnt_zero (cnt_zero),
        .md_done  (md_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A reload in the final busy cycle keeps the unit occupied without a gap.
    always_comb begin
        state_nxt = state;
        if (md_accept) begin
            state_nxt = MD_BUSY;
        end else if ((state == MD_BUSY) && cnt_zero) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        if (reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (flush) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign md_busy = (state == MD_BUSY) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MD_LATENCY=4: load-use, zero
// register, mult/div countdown, flush priority, back-to-back mult, reset, saturation.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  IF_ID_RS, IF_ID_RT, ID_EX_RT;
    logic        ID_uses_RT, ID_EX_Mem_Read, EX_branch_taken, ID_md_start, ID_md_read;
    logic        PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush;
    logic        md_busy, md_done;
    logic [15:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .MD_LATENCY  (4),
        .REG_ADDR_W  (5),
        .STALL_CNT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IF_ID_RS        (IF_ID_RS),
        .IF_ID_RT        (IF_ID_RT),
        .ID_uses_RT      (ID_uses_RT),
        .ID_EX_RT        (ID_EX_RT),
        .ID_EX_Mem_Read  (ID_EX_Mem_Read),
        .EX_branch_taken (EX_branch_taken),
        .ID_md_start     (ID_md_start),
        .ID_md_read      (ID_md_read),
        .PC_Write        (PC_Write),
        .IF_ID_Write     (IF_ID_Write),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cycles    (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; combinational outputs are checked 1ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        IF_ID_RS = 5'd1; IF_ID_RT = 5'd2; ID_uses_RT = 1'b0;
        ID_EX_RT = 5'd3; ID_EX_Mem_Read = 1'b0; EX_branch_taken = 1'b0;
        ID_md_start = 1'b0; ID_md_read = 1'b0;
    endtask

    task automatic chk_ctl(input string tag, input logic pc, input logic bub, input logic fl);
        #1;
        check({tag, ".pc"},    {31'd0, PC_Write},     {31'd0, pc});
        check({tag, ".ifid"},  {31'd0, IF_ID_Write},  {31'd0, pc});
        check({tag, ".bub"},   {31'd0, ID_EX_Bubble}, {31'd0, bub});
        check({tag, ".flush"}, {30'd0, IF_ID_Flush, ID_EX_Flush}, {30'd0, fl, fl});
    endtask

    task automatic chk_md(input string tag, input logic busy, input logic done);
        #1;
        check({tag, ".busy"}, {31'd0, md_busy}, {31'd0, busy});
        check({tag, ".done"}, {31'd0, md_done}, {31'd0, done});
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        #1;
        check({tag, ".cnt"}, {16'd0, stall_cycles}, {16'd0, exp});
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) next_cycle();
        chk_ctl("rst", 1'b0, 1'b1, 1'b0);
        chk_md("rst", 1'b0, 1'b0);
        chk_cnt("rst", 16'd0);

        // Load-use on rs
        next_cycle(); reset = 1'b0; idle();
        chk_ctl("run", 1'b1, 1'b0, 1'b0);
        next_cycle(); ID_EX_Mem_Read = 1'b1; ID_EX_RT = 5'd8; IF_ID_RS = 5'd8;
        chk_ctl("lu_rs", 1'b0, 1'b1, 1'b0);
        chk_cnt("lu_rs", 16'd0);
        next_cycle(); idle();
        chk_ctl("lu_rs_clr", 1'b1, 1'b0, 1'b0);
        chk_cnt("lu_rs_clr", 16'd1);

        // Zero register and unused rt
        next_cycle(); ID_EX_Mem_Read = 1'b1; ID_EX_RT = 5'd0; IF_ID_RS = 5'd0;
        chk_ctl("zero_reg", 1'b1, 1'b0, 1'b0);
        next_cycle(); IF_ID_RS = 5'd1; ID_EX_RT = 5'd9; IF_ID_RT = 5'd9; ID_uses_RT = 1'b0;
        chk_ctl("rt_unused", 1'b1, 1'b0, 1'b0);
        next_cycle(); ID_uses_RT = 1'b1;
        chk_ctl("rt_used", 1'b0, 1'b1, 1'b0);
        next_cycle(); idle();
        chk_cnt("rt_used", 16'd2);

        // Mult then dependent mfhi
        next_cycle(); ID_md_start = 1'b1;
        chk_ctl("mult_t0", 1'b1, 1'b0, 1'b0);
        chk_md("mult_t0", 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle(); idle(); ID_md_read = 1'b1;
            chk_ctl($sformatf("mfhi_t%0d", i), 1'b0, 1'b1, 1'b0);
            chk_md($sformatf("mfhi_t%0d", i), 1'b1, 1'b0);
        end
        next_cycle();
        chk_ctl("mfhi_t4", 1'b1, 1'b0, 1'b0);
        chk_md("mfhi_t4", 1'b1, 1'b1);
        next_cycle(); idle();
        chk_md("mfhi_t5", 1'b0, 1'b0);
        chk_cnt("mfhi", 16'd5);

        // Mult then unrelated addu
        next_cycle(); ID_md_start = 1'b1;
        next_cycle(); idle();
        chk_ctl("addu_t1", 1'b1, 1'b0, 1'b0);
        chk_md("addu_t1", 1'b1, 1'b0);
        repeat (2) next_cycle();
        next_cycle();
        chk_md("addu_t4", 1'b1, 1'b1);
        next_cycle();
        chk_md("addu_t5", 1'b0, 1'b0);
        chk_cnt("addu", 16'd5);

        // Flush beats load-use and md_start
        next_cycle(); EX_branch_taken = 1'b1; ID_EX_Mem_Read = 1'b1;
        ID_EX_RT = 5'd8; IF_ID_RS = 5'd8; ID_md_start = 1'b1;
        chk_ctl("flush", 1'b1, 1'b0, 1'b1);
        next_cycle(); idle();
        chk_ctl("post_flush", 1'b1, 1'b0, 1'b0);
        chk_md("post_flush", 1'b0, 1'b0);
        chk_cnt("post_flush", 16'd5);

        // Back-to-back mult in the final busy cycle
        next_cycle(); ID_md_start = 1'b1;
        next_cycle(); idle();
        repeat (2) next_cycle();
        next_cycle(); ID_md_start = 1'b1;
        chk_ctl("b2b_t4", 1'b1, 1'b0, 1'b0);
        chk_md("b2b_t4", 1'b1, 1'b1);
        next_cycle(); idle();
        chk_md("b2b_t5", 1'b1, 1'b0);
        repeat (2) next_cycle();
        chk_md("b2b_t7", 1'b1, 1'b0);
        next_cycle();
        chk_md("b2b_t8", 1'b1, 1'b1);
        next_cycle();
        chk_md("b2b_t9", 1'b0, 1'b0);
        chk_cnt("b2b", 16'd5);

        // Reset while md_cnt is 2
        next_cycle(); ID_md_start = 1'b1;
        next_cycle(); idle();
        next_cycle(); reset = 1'b1;
        chk_ctl("rst_mid", 1'b0, 1'b1, 1'b0);
        next_cycle();
        chk_ctl("rst_hold", 1'b0, 1'b1, 1'b0);
        chk_md("rst_hold", 1'b0, 1'b0);
        chk_cnt("rst_hold", 16'd0);
        next_cycle(); reset = 1'b0;
        chk_md("rst_rel", 1'b0, 1'b0);
        next_cycle();
        chk_md("rst_rel2", 1'b0, 1'b0);

        // Saturation under sustained load-use
        next_cycle(); ID_EX_Mem_Read = 1'b1; ID_EX_RT = 5'd8; IF_ID_RS = 5'd8;
        repeat (65534) next_cycle();
        chk_cnt("sat_m1", 16'hFFFE);
        next_cycle();
        chk_cnt("sat", 16'hFFFF);
        repeat (3) next_cycle();
        chk_cnt("sat_hold", 16'hFFFF);
        chk_ctl("sat_hold", 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard/stall sequencer for the 5-stage MIPS core; sits beside the forwarding unit in ID and controls the PC, IF/ID and ID/EX pipeline registers.
- Covers the hazards forwarding cannot resolve: load-use (1-cycle bubble), taken-branch flush of IF/ID and ID/EX, and the multi-cycle multiply/divide unit (busy countdown, stall of dependent instructions).
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue (>= 2).
- REG_ADDR_W, 5, register specifier width.
- STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- IF_ID_RS  in  REG_ADDR_W  rs of the instruction in ID.
- IF_ID_RT  in  REG_ADDR_W  rt of the instruction in ID.
- ID_uses_RT  in  1  ID instruction reads rt as a source.
- ID_EX_RT  in  REG_ADDR_W  destination rt of the instruction in EX.
- ID_EX_Mem_Read  in  1  EX instruction is a load.
- EX_branch_taken  in  1  branch resolved taken in EX this cycle.
- ID_md_start  in  1  ID instruction is mult/multu/div/divu.
- ID_md_read  in  1  ID instruction is mfhi/mflo.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  zero ID/EX control fields (insert nop).
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- md_busy  out  1  mult/div unit occupied (state MD_BUSY).
- md_done  out  1  1-cycle pulse in the final busy cycle.
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN, MD_BUSY. Registers: state, md_cnt (clog2(MD_LATENCY) bits), stall_cycles.
- The reset behaviour below takes effect at the clock edge while reset=1. State becomes RUN, md_cnt 0, stall_cycles 0.
- While reset=1: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, flushes 0, md_busy 0, md_done 0.
- Hazard terms are combinational, same cycle, zero latency:
  - load_use = ID_EX_Mem_Read & ID_EX_RT!=0 & (ID_EX_RT==IF_ID_RS | (ID_uses_RT & ID_EX_RT==IF_ID_RT)).
  - md_conf = state==MD_BUSY & md_cnt!=0 & (ID_md_start | ID_md_read).
- Priority: reset > branch flush > load_use > md_conf.
- Flush (EX_branch_taken=1): IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0. Any stall request is ignored, and ID_md_start is not accepted because the ID instruction is squashed.
- Stall (load_use | md_conf, no flush): PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. stall_cycles increments and saturates at all-ones.
- Otherwise: PC_Write=1, IF_ID_Write=1, all other control outputs 0.
- md accept = ID_md_start & no flush & no stall. Accept loads md_cnt=MD_LATENCY-1 and sets state to MD_BUSY.
- MD_BUSY: md_cnt decrements every cycle, independent of stalls and flushes (the issued op is never cancelled).
- When md_cnt==0 in MD_BUSY: md_done=1, md_conf is false, and the state returns to RUN. A simultaneous accepted md_start reloads the counter and stays in MD_BUSY; md_done is still 1.
- Non-md instructions in ID proceed freely during MD_BUSY.
- md_busy = (state==MD_BUSY), registered.
- Reset mid-busy: the countdown is abandoned and the state returns to RUN.

Decomposition:
- Shared package (mips_pkg): state encoding (RUN=1'b0, MD_BUSY=1'b1), REG_ADDR_W, the zero-register constant, and the default MD_LATENCY.
- One natural sub-module: md_busy_counter, covering the load/decrement/zero-detect counter with the md_done output; the parent holds the hazard logic, the priority mux and stall_cycles.

Test Plan:
1. Load-use on rs: lw $8 in EX (ID_EX_Mem_Read=1, ID_EX_RT=8), ID rs=8 -> exactly one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles goes 0->1; next cycle clears once the load leaves EX.
2. Zero register and unused rt: ID_EX_RT=0 with rs=0 -> no stall; ID_EX_RT=9, IF_ID_RT=9, ID_uses_RT=0 -> no stall; the same with ID_uses_RT=1 -> stall.
3. Mult/div countdown (MD_LATENCY=4): mult accepted at cycle t, then mfhi in ID at t+1 -> stall at t+1..t+3, md_done=1 at t+4, mfhi proceeds at t+4, md_busy=0 from t+5; an unrelated addu at t+1 proceeds without stall.
4. Flush priority: EX_branch_taken=1 together with load_use=1 and ID_md_start=1 -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1, no bubble, md_busy stays 0, stall_cycles unchanged.
5. Back-to-back mult: second mult in ID in the md_cnt==0 cycle -> accepted with no stall, md_done=1, md_busy stays 1, and a new 4-cycle countdown starts.
6. Reset mid-operation: reset=1 at md_cnt=2 -> at the next edge md_busy=0, stall_cycles=0, and PC_Write=0 while reset is held. A saturation check preloads stall_cycles to 0xFFFF via sustained stall and confirms it holds at 0xFFFF.
